// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller: FSM state encoding,
// line-count limit and default handler-vector layout.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RET     = 2'd3
    } state_e;

    localparam int NUM_IRQ_MAX = 8;
    // Wide enough to index any of NUM_IRQ_MAX lines.
    localparam int ID_W = 3;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam int          DEF_VEC_STRIDE = 8;

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt line: 2-flop synchroniser followed by a rising-edge detector.
// The history flop clears on reset, so a line already high at release is seen as an edge.
module int_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= irq;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending lines, enable mask, fixed-priority
// arbitration (lowest index wins) and the request / service / return sequence.
module int_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int          VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic [31:0]        pc_cur,
    input  logic               RFE,
    output logic               int_req,
    output logic [31:0]        vector,
    output logic [31:0]        epc,
    output logic               rfe_valid,
    output logic [NUM_IRQ-1:0] cause,
    output logic               in_service
);

    state_e              state_reg, state_next;
    logic [ID_W-1:0]     win_id_reg, win_id_next;
    logic [NUM_IRQ-1:0]  pending_reg, pending_next;
    logic [NUM_IRQ-1:0]  mask_reg, mask_next;
    logic [31:0]         epc_reg, epc_next;
    logic [NUM_IRQ-1:0]  cause_reg, cause_next;

    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  win_onehot;
    logic [ID_W-1:0]     winner;
    logic                accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            int_sync_edge u_sync_edge (
                .clk   (clk),
                .reset (reset),
                .irq   (irq[gi]),
                .rise  (rise[gi])
            );
            assign win_onehot[gi] = (win_id_reg == ID_W'(gi));
        end
    endgenerate

    assign eligible = pending_reg & mask_reg;

    // Scan from the top down so the lowest eligible index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        win_id_next = win_id_reg;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    state_next  = REQ;
                    win_id_next = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = SERVICE;
                    accept     = 1'b1;
                end
            end
            SERVICE: begin
                if (RFE) begin
                    state_next = RET;
                end
            end
            RET:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A fresh edge on the line being accepted survives the clear.
    always_comb begin
        pending_next = (pending_reg & ~(accept ? win_onehot : '0)) | rise;
        mask_next    = mask_we ? mask_wdata : mask_reg;
        epc_next     = accept ? pc_cur : epc_reg;
        cause_next   = cause_reg;
        if (accept) begin
            cause_next = win_onehot;
        end else if (state_reg == RET) begin
            cause_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            win_id_reg  <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
            epc_reg     <= '0;
            cause_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            win_id_reg  <= win_id_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            epc_reg     <= epc_next;
            cause_reg   <= cause_next;
        end
    end

    assign int_req    = (state_reg == REQ);
    assign in_service = (state_reg == SERVICE);
    assign rfe_valid  = (state_reg == RET);
    assign vector     = (state_reg == REQ) ? (VEC_BASE + 32'(win_id_reg) * 32'(VEC_STRIDE)) : 32'h0;
    assign epc        = epc_reg;
    assign cause      = cause_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: hand-computed expectations checked with immediate assertions.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq = 4'b0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = 4'b0;
    logic        int_ack = 1'b0;
    logic [31:0] pc_cur = 32'h0;
    logic        RFE = 1'b0;
    logic        int_req;
    logic [31:0] vector;
    logic [31:0] epc;
    logic        rfe_valid;
    logic [3:0]  cause;
    logic        in_service;

    int total = 0;
    int passed = 0;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .pc_cur     (pc_cur),
        .RFE        (RFE),
        .int_req    (int_req),
        .vector     (vector),
        .epc        (epc),
        .rfe_valid  (rfe_valid),
        .cause      (cause),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
            $display("check %-24s observed %h expected %h ok", tag, got, exp);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_epc);
        check({tag, ".int_req"},    32'(int_req),    32'h0);
        check({tag, ".vector"},     vector,          32'h0);
        check({tag, ".epc"},        epc,             exp_epc);
        check({tag, ".rfe_valid"},  32'(rfe_valid),  32'h0);
        check({tag, ".cause"},      32'(cause),      32'h0);
        check({tag, ".in_service"}, 32'(in_service), 32'h0);
    endtask

    initial begin
        // Reset held with irq[1] high and mask cleared.
        irq = 4'b0010;
        #12;
        check_idle_outputs("rst", 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("masked_no_req", 32'(int_req), 32'h0);
        end
        mask_we = 1'b1; mask_wdata = 4'hF;
        tick();
        mask_we = 1'b0;
        check("mask_wr_edge_req", 32'(int_req), 32'h0);
        tick();
        check("mask_req", 32'(int_req), 32'h1);
        check("mask_vec", vector, 32'h108);
        int_ack = 1'b1; pc_cur = 32'h1000;
        tick();
        int_ack = 1'b0;
        check("l1_epc", epc, 32'h1000);
        check("l1_cause", 32'(cause), 32'h2);
        check("l1_in_service", 32'(in_service), 32'h1);
        RFE = 1'b1;
        tick();
        RFE = 1'b0;
        check("l1_rfe_valid", 32'(rfe_valid), 32'h1);
        check("l1_ret_insvc", 32'(in_service), 32'h0);
        tick();
        check_idle_outputs("l1_done", 32'h1000);
        irq = 4'b0000;
        tick(); tick(); tick();

        // irq[2] rises: request follows 4 edges later.
        irq = 4'b0100;
        tick(); check("l2_e0", 32'(int_req), 32'h0);
        tick(); check("l2_e1", 32'(int_req), 32'h0);
        tick(); check("l2_e2", 32'(int_req), 32'h0);
        tick(); check("l2_e3_req", 32'(int_req), 32'h1);
        check("l2_vec", vector, 32'h110);
        int_ack = 1'b1; pc_cur = 32'h0000_2040;
        tick();
        int_ack = 1'b0;
        check("l2_epc", epc, 32'h2040);
        check("l2_cause", 32'(cause), 32'h4);
        check("l2_in_service", 32'(in_service), 32'h1);
        check("l2_req_drop", 32'(int_req), 32'h0);

        // irq[0] arrives during service and must wait for the return.
        irq = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("svc_block_req", 32'(int_req), 32'h0);
        end
        RFE = 1'b1;
        tick();
        RFE = 1'b0;
        check("l2_rfe_valid", 32'(rfe_valid), 32'h1);
        check("l2_rfe_epc", epc, 32'h2040);
        tick();
        check("l2_rfe_pulse_end", 32'(rfe_valid), 32'h0);
        check("l2_cause_clr", 32'(cause), 32'h0);
        check("l0_not_yet", 32'(int_req), 32'h0);
        tick();
        check("l0_req", 32'(int_req), 32'h1);
        check("l0_vec", vector, 32'h100);
        int_ack = 1'b1; pc_cur = 32'h3000;
        tick();
        int_ack = 1'b0;
        check("l0_cause", 32'(cause), 32'h1);
        check("l0_epc", epc, 32'h3000);
        RFE = 1'b1;
        tick();
        RFE = 1'b0;
        tick();
        irq = 4'b0000;
        tick(); tick(); tick();
        check("quiet_idle", 32'(int_req), 32'h0);

        // irq[3] and irq[1] together: line 1 first, then line 3.
        irq = 4'b1010;
        tick(); tick(); tick(); tick();
        check("pri_req", 32'(int_req), 32'h1);
        check("pri_vec1", vector, 32'h108);
        int_ack = 1'b1; pc_cur = 32'h4000;
        tick();
        int_ack = 1'b0;
        check("pri_cause1", 32'(cause), 32'h2);
        RFE = 1'b1;
        tick();
        RFE = 1'b0;
        check("pri_rfe_epc", epc, 32'h4000);
        tick();
        check("pri_gap", 32'(int_req), 32'h0);
        tick();
        check("pri_req3", 32'(int_req), 32'h1);
        check("pri_vec3", vector, 32'h118);
        int_ack = 1'b1; pc_cur = 32'h5000;
        tick();
        int_ack = 1'b0;
        check("pri_cause3", 32'(cause), 32'h8);
        RFE = 1'b1;
        tick();
        RFE = 1'b0;
        tick();

        // RFE and int_ack in IDLE are ignored.
        RFE = 1'b1; int_ack = 1'b1; pc_cur = 32'hDEAD_BEEF;
        tick();
        check_idle_outputs("idle_ign", 32'h5000);
        tick();
        RFE = 1'b0; int_ack = 1'b0;
        check_idle_outputs("idle_ign2", 32'h5000);

        // Asynchronous reset while in REQ.
        irq = 4'b0000;
        tick(); tick(); tick();
        irq = 4'b0001;
        tick(); tick(); tick(); tick();
        check("pre_rst_req", 32'(int_req), 32'h1);
        reset = 1'b0;
        #2;
        check_idle_outputs("rst_req", 32'h0);
        irq = 4'b0000;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_req", 32'(int_req), 32'h0);
        end

        // Asynchronous reset while in SERVICE.
        mask_we = 1'b1; mask_wdata = 4'hF;
        tick();
        mask_we = 1'b0;
        irq = 4'b0100;
        tick(); tick(); tick(); tick();
        check("svc_setup_req", 32'(int_req), 32'h1);
        int_ack = 1'b1; pc_cur = 32'h6000;
        tick();
        int_ack = 1'b0;
        check("svc_setup_insvc", 32'(in_service), 32'h1);
        reset = 1'b0;
        #2;
        check_idle_outputs("rst_svc", 32'h0);
        irq = 4'b0000;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_svc", 32'(int_req), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
